// File: rtl/id_issue_queue_if.sv
// Decode-side and issue-side bundle for the ID/issue queue.
// The queue side uses slave; the decoder/issue environment drives master.
interface id_issue_queue_if #(
  parameter int DEPTH     = 4,
  parameter int IN_PORTS  = 2,
  parameter int OUT_PORTS = 2,
  parameter int PAYLOAD_W = 64
);
  logic                           flush_i;
  logic                           single_cf_i;
  logic [IN_PORTS-1:0]            dec_valid_i;
  logic [IN_PORTS*PAYLOAD_W-1:0]  dec_payload_i;
  logic [IN_PORTS*32-1:0]         dec_instr_i;
  logic [IN_PORTS-1:0]            dec_cf_i;
  logic [IN_PORTS-1:0]            dec_ready_o;
  logic [OUT_PORTS-1:0]           iss_valid_o;
  logic [OUT_PORTS*PAYLOAD_W-1:0] iss_payload_o;
  logic [OUT_PORTS*32-1:0]        iss_instr_o;
  logic [OUT_PORTS-1:0]           iss_cf_o;
  logic [OUT_PORTS-1:0]           iss_ack_i;
  logic [$clog2(DEPTH):0]         occupancy_o;

  modport slave (
    input  flush_i, single_cf_i, dec_valid_i, dec_payload_i, dec_instr_i,
           dec_cf_i, iss_ack_i,
    output dec_ready_o, iss_valid_o, iss_payload_o, iss_instr_o, iss_cf_o,
           occupancy_o
  );

  modport master (
    output flush_i, single_cf_i, dec_valid_i, dec_payload_i, dec_instr_i,
           dec_cf_i, iss_ack_i,
    input  dec_ready_o, iss_valid_o, iss_payload_o, iss_instr_o, iss_cf_o,
           occupancy_o
  );
endinterface

// File: rtl/id_issue_queue.sv
// Multi-lane circular queue between decode and issue: accepts up to IN_PORTS
// entries and presents up to OUT_PORTS in-order issue candidates per cycle.
module id_issue_queue #(
  parameter int DEPTH     = 4,
  parameter int IN_PORTS  = 2,
  parameter int OUT_PORTS = 2,
  parameter int PAYLOAD_W = 64
) (
  input logic              clk_i,
  input logic              rst_i,
  id_issue_queue_if.slave  q_if
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = CW + 1;

  logic [PW-1:0]        rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PAYLOAD_W-1:0] pay_q [DEPTH];
  logic [PAYLOAD_W-1:0] pay_d [DEPTH];
  logic [31:0]          ins_q [DEPTH];
  logic [31:0]          ins_d [DEPTH];
  logic [DEPTH-1:0]     cf_q, cf_d;

  logic [CW-1:0]        n_ack, n_in, n_acc;
  logic [FW-1:0]        free;
  logic [IN_PORTS-1:0]  dec_ready;

  logic [OUT_PORTS-1:0]           iss_valid;
  logic [OUT_PORTS*PAYLOAD_W-1:0] iss_payload;
  logic [OUT_PORTS*32-1:0]        iss_instr;
  logic [OUT_PORTS-1:0]           iss_cf;
  logic                           cf_seen;

  always_comb begin : accept_calc
    n_ack = '0;
    n_in  = '0;
    for (int k = 0; k < OUT_PORTS; k++) n_ack = n_ack + CW'(q_if.iss_ack_i[k]);
    for (int k = 0; k < IN_PORTS; k++)  n_in  = n_in  + CW'(q_if.dec_valid_i[k]);
    // Same-cycle acks free slots, so a full queue can still take input.
    free = FW'(DEPTH) - FW'(cnt_q) + FW'(n_ack);
    if (q_if.flush_i || rst_i)   n_acc = '0;
    else if (FW'(n_in) < free)   n_acc = n_in;
    else                         n_acc = free[CW-1:0];
    for (int k = 0; k < IN_PORTS; k++) dec_ready[k] = (CW'(k) < n_acc);
  end

  always_comb begin : next_state
    pay_d = pay_q;
    ins_d = ins_q;
    cf_d  = cf_q;
    for (int k = 0; k < IN_PORTS; k++) begin
      if (dec_ready[k]) begin
        pay_d[wr_q + PW'(k)] = q_if.dec_payload_i[k*PAYLOAD_W +: PAYLOAD_W];
        ins_d[wr_q + PW'(k)] = q_if.dec_instr_i[k*32 +: 32];
        cf_d[wr_q + PW'(k)]  = q_if.dec_cf_i[k];
      end
    end
    if (q_if.flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      rd_d  = rd_q + n_ack[PW-1:0];
      wr_d  = wr_q + n_acc[PW-1:0];
      cnt_d = cnt_q + n_acc - n_ack;
    end
  end

  always_comb begin : present
    cf_seen     = 1'b0;
    iss_valid   = '0;
    iss_payload = '0;
    iss_instr   = '0;
    iss_cf      = '0;
    for (int k = 0; k < OUT_PORTS; k++) begin
      // Everything behind the first control-flow entry is held back in single_cf mode.
      iss_valid[k] = (CW'(k) < cnt_q) && !(q_if.single_cf_i && cf_seen);
      iss_payload[k*PAYLOAD_W +: PAYLOAD_W] = pay_q[rd_q + PW'(k)];
      iss_instr[k*32 +: 32]                 = ins_q[rd_q + PW'(k)];
      iss_cf[k]                             = cf_q[rd_q + PW'(k)];
      if ((CW'(k) < cnt_q) && cf_q[rd_q + PW'(k)]) cf_seen = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      pay_q <= '{default: '0};
      ins_q <= '{default: '0};
      cf_q  <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      pay_q <= pay_d;
      ins_q <= ins_d;
      cf_q  <= cf_d;
    end
  end

  assign q_if.dec_ready_o   = dec_ready;
  assign q_if.iss_valid_o   = iss_valid;
  assign q_if.iss_payload_o = iss_payload;
  assign q_if.iss_instr_o   = iss_instr;
  assign q_if.iss_cf_o      = iss_cf;
  assign q_if.occupancy_o   = cnt_q;

endmodule

// File: tb/tb_id_issue_queue.sv
// Directed bench for id_issue_queue: stimulus pushes expected entries into a
// scoreboard, a negedge monitor pops and compares every acked issue lane.
module tb_id_issue_queue;
  localparam int DEPTH = 4;
  localparam int IN_PORTS = 2;
  localparam int OUT_PORTS = 2;
  localparam int PAYLOAD_W = 64;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] payload;
    logic        cf;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  ent_t exp_q[$];

  id_issue_queue_if #(.DEPTH(DEPTH), .IN_PORTS(IN_PORTS), .OUT_PORTS(OUT_PORTS),
                      .PAYLOAD_W(PAYLOAD_W)) q_if ();

  id_issue_queue #(.DEPTH(DEPTH), .IN_PORTS(IN_PORTS), .OUT_PORTS(OUT_PORTS),
                   .PAYLOAD_W(PAYLOAD_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .q_if  (q_if)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_instr(input int id);
    return 32'hA000_0000 | 32'(id);
  endfunction

  function automatic logic [63:0] mk_pay(input int id);
    return {32'h5A5A_0000 | 32'(id), ~mk_instr(id)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    q_if.dec_valid_i   = '0;
    q_if.dec_instr_i   = '0;
    q_if.dec_payload_i = '0;
    q_if.dec_cf_i      = '0;
    q_if.iss_ack_i     = '0;
    q_if.flush_i       = 1'b0;
  endtask

  // One clock of stimulus; erdy is the hand-computed dec_ready for this cycle.
  task automatic cyc(input logic [1:0] v, input int id0, input int id1,
                     input logic [1:0] cf, input logic [1:0] ack,
                     input logic fl, input logic [1:0] erdy);
    q_if.dec_valid_i   = v;
    q_if.dec_instr_i   = {mk_instr(id1), mk_instr(id0)};
    q_if.dec_payload_i = {mk_pay(id1), mk_pay(id0)};
    q_if.dec_cf_i      = cf;
    q_if.iss_ack_i     = ack;
    q_if.flush_i       = fl;
    @(negedge clk);
    chk("dec_ready", 64'(q_if.dec_ready_o), 64'(erdy));
    if (erdy[0]) exp_q.push_back(ent_t'{mk_instr(id0), mk_pay(id0), cf[0]});
    if (erdy[1]) exp_q.push_back(ent_t'{mk_instr(id1), mk_pay(id1), cf[1]});
    @(posedge clk);
    #1;
    idle();
  endtask

  // Monitor: every acked lane must match the scoreboard head, in lane order.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (!rst && !q_if.flush_i) begin
        assert (!(q_if.iss_ack_i[1] && !q_if.iss_ack_i[0])) else begin
          n_cmp++;
          n_err++;
          $display("FAIL ack_contig: ack %b is not contiguous", q_if.iss_ack_i);
        end
        for (int k = 0; k < OUT_PORTS; k++) begin
          if (q_if.iss_ack_i[k]) begin
            chk("ack_lane_valid", 64'(q_if.iss_valid_o[k]), 64'd1);
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_err++;
              $display("FAIL sb_empty: lane %0d acked instr %h, expected nothing", k,
                       q_if.iss_instr_o[k*32 +: 32]);
            end else begin
              e = exp_q.pop_front();
              chk("iss_instr", 64'(q_if.iss_instr_o[k*32 +: 32]), 64'(e.instr));
              chk("iss_payload", q_if.iss_payload_o[k*PAYLOAD_W +: PAYLOAD_W], e.payload);
              chk("iss_cf", 64'(q_if.iss_cf_o[k]), 64'(e.cf));
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    q_if.single_cf_i = 1'b0;
    q_if.dec_valid_i = 2'b11;
    #2;
    chk("rst_ready", 64'(q_if.dec_ready_o), 64'd0);
    chk("rst_occ", 64'(q_if.occupancy_o), 64'd0);
    chk("rst_valid", 64'(q_if.iss_valid_o), 64'd0);
    chk("rst_instr0", 64'(q_if.iss_instr_o[31:0]), 64'd0);
    chk("rst_payload0", q_if.iss_payload_o[63:0], 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();

    // Basic two-lane accept, no bypass
    cyc(2'b11, 1, 2, 2'b00, 2'b00, 1'b0, 2'b11);
    chk("ab_valid", 64'(q_if.iss_valid_o), 64'b11);
    chk("ab_occ", 64'(q_if.occupancy_o), 64'd2);
    chk("ab_lane0", 64'(q_if.iss_instr_o[31:0]), 64'(mk_instr(1)));
    chk("ab_lane1", 64'(q_if.iss_instr_o[63:32]), 64'(mk_instr(2)));

    // Fill, then full with single ack: only lane 0 accepted
    cyc(2'b11, 3, 4, 2'b00, 2'b00, 1'b0, 2'b11);
    chk("full_occ", 64'(q_if.occupancy_o), 64'd4);
    cyc(2'b11, 5, 6, 2'b00, 2'b01, 1'b0, 2'b01);
    chk("full_ack1_occ", 64'(q_if.occupancy_o), 64'd4);
    chk("full_ack1_lane0", 64'(q_if.iss_instr_o[31:0]), 64'(mk_instr(2)));

    // Three full rotations with double ack + double input
    for (int r = 0; r < 6; r++) begin
      cyc(2'b11, 7 + 2*r, 8 + 2*r, 2'b00, 2'b11, 1'b0, 2'b11);
      chk("rot_occ", 64'(q_if.occupancy_o), 64'd4);
    end
    cyc(2'b00, 0, 0, 2'b00, 2'b11, 1'b0, 2'b00);
    cyc(2'b00, 0, 0, 2'b00, 2'b11, 1'b0, 2'b00);
    chk("drain_occ", 64'(q_if.occupancy_o), 64'd0);
    chk("drain_valid", 64'(q_if.iss_valid_o), 64'd0);

    // Single control-flow mode: [branch, add]
    cyc(2'b11, 20, 21, 2'b01, 2'b00, 1'b0, 2'b11);
    chk("cf_off_valid", 64'(q_if.iss_valid_o), 64'b11);
    q_if.single_cf_i = 1'b1;
    #1;
    chk("cf_on_valid", 64'(q_if.iss_valid_o), 64'b01);
    chk("cf_on_flag0", 64'(q_if.iss_cf_o[0]), 64'd1);
    cyc(2'b00, 0, 0, 2'b00, 2'b01, 1'b0, 2'b00);
    chk("cf_after_valid", 64'(q_if.iss_valid_o), 64'b01);
    chk("cf_after_lane0", 64'(q_if.iss_instr_o[31:0]), 64'(mk_instr(21)));
    chk("cf_after_occ", 64'(q_if.occupancy_o), 64'd1);
    // Branch in lane 1 only: both lanes still presented
    cyc(2'b11, 22, 23, 2'b10, 2'b01, 1'b0, 2'b11);
    chk("cf_lane1_valid", 64'(q_if.iss_valid_o), 64'b11);
    cyc(2'b00, 0, 0, 2'b00, 2'b11, 1'b0, 2'b00);
    q_if.single_cf_i = 1'b0;
    chk("cf_drain_occ", 64'(q_if.occupancy_o), 64'd0);

    // Flush with 3 entries, valid input and an ack
    cyc(2'b11, 30, 31, 2'b00, 2'b00, 1'b0, 2'b11);
    cyc(2'b01, 32, 0, 2'b00, 2'b00, 1'b0, 2'b01);
    chk("pre_flush_occ", 64'(q_if.occupancy_o), 64'd3);
    cyc(2'b11, 33, 34, 2'b00, 2'b01, 1'b1, 2'b00);
    chk("flush_occ", 64'(q_if.occupancy_o), 64'd0);
    chk("flush_valid", 64'(q_if.iss_valid_o), 64'd0);
    exp_q.delete();

    // Asynchronous reset mid-cycle with 3 entries
    cyc(2'b11, 40, 41, 2'b00, 2'b00, 1'b0, 2'b11);
    cyc(2'b01, 42, 0, 2'b00, 2'b00, 1'b0, 2'b01);
    chk("pre_rst_occ", 64'(q_if.occupancy_o), 64'd3);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_occ", 64'(q_if.occupancy_o), 64'd0);
    chk("arst_valid", 64'(q_if.iss_valid_o), 64'd0);
    chk("arst_instr0", 64'(q_if.iss_instr_o[31:0]), 64'd0);
    q_if.dec_valid_i = 2'b11;
    #1;
    chk("arst_ready", 64'(q_if.dec_ready_o), 64'd0);
    idle();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(2'b11, 43, 44, 2'b00, 2'b00, 1'b0, 2'b11);
    chk("post_rst_occ", 64'(q_if.occupancy_o), 64'd2);
    chk("post_rst_lane0", 64'(q_if.iss_instr_o[31:0]), 64'(mk_instr(43)));
    cyc(2'b00, 0, 0, 2'b00, 2'b11, 1'b0, 2'b00);
    chk("final_occ", 64'(q_if.occupancy_o), 64'd0);

    repeat (2) @(posedge clk);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
